// File: rtl/ex_stage_md_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, mul/div ops, forward selects, FSM states.
package ex_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MFHI  = 3'd5,
    MD_MFLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Ops that launch the iterative unit.
  function automatic logic md_is_start(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mf(logic [2:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// ID/EX-to-EX/MEM bundle of the execute stage; master = upstream driver, slave = stage.
interface ex_stage_md_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              in_valid;
  logic              flush_in;
  logic [DATA_W-1:0] reg_data1_in;
  logic [DATA_W-1:0] reg_data2_in;
  logic [DATA_W-1:0] imm_in;
  logic [4:0]        shamt_in;
  logic [1:0]        forwardA;
  logic [1:0]        forwardB;
  logic [DATA_W-1:0] ex_mem_result_in;
  logic [DATA_W-1:0] mem_wb_result_in;
  logic              alu_src_in;
  logic              use_shamt_in;
  logic [3:0]        alu_control_in;
  logic [2:0]        md_op_in;
  logic [4:0]        rd_addr_in;
  logic              stall_out;
  logic              out_valid;
  logic [DATA_W-1:0] result_out;
  logic [DATA_W-1:0] store_data_out;
  logic              zero_out;
  logic [4:0]        rd_addr_out;

  modport master (
    output in_valid, flush_in, reg_data1_in, reg_data2_in, imm_in, shamt_in,
           forwardA, forwardB, ex_mem_result_in, mem_wb_result_in,
           alu_src_in, use_shamt_in, alu_control_in, md_op_in, rd_addr_in,
    input  stall_out, out_valid, result_out, store_data_out, zero_out, rd_addr_out
  );

  modport slave (
    input  in_valid, flush_in, reg_data1_in, reg_data2_in, imm_in, shamt_in,
           forwardA, forwardB, ex_mem_result_in, mem_wb_result_in,
           alu_src_in, use_shamt_in, alu_control_in, md_op_in, rd_addr_in,
    output stall_out, out_valid, result_out, store_data_out, zero_out, rd_addr_out
  );
endinterface

// File: rtl/ex_stage_md_alu.sv
// Combinational single-cycle ALU; shifts move operand B by the low five bits of operand A.
module alu
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        ctrl_i,
  output logic [DATA_W-1:0] y_c,
  output logic              zero_c
);
  logic [4:0] sh;
  assign sh = a_i[4:0];

  always_comb begin
    y_c = '0;
    case (ctrl_i)
      ALU_AND:  y_c = a_i & b_i;
      ALU_OR:   y_c = a_i | b_i;
      ALU_ADD:  y_c = a_i + b_i;
      ALU_XOR:  y_c = a_i ^ b_i;
      ALU_SLL:  y_c = b_i << sh;
      ALU_SRL:  y_c = b_i >> sh;
      ALU_SUB:  y_c = a_i - b_i;
      ALU_SLT:  y_c = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SRA:  y_c = $signed(b_i) >>> sh;
      ALU_SLTU: y_c = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      ALU_NOR:  y_c = ~(a_i | b_i);
      default:  y_c = '0;
    endcase
  end

  assign zero_c = (y_c == '0);
endmodule

// File: rtl/ex_stage_md_muldiv.sv
// Iterative radix-2 multiply/divide with HI/LO; compiled only when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output md_state_e         state_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int unsigned     CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d, wrk_q, wrk_d, opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic              is_div_q, is_div_d, neg_x_q, neg_x_d, neg_a_q, neg_a_d, div0_q, div0_d;

  logic              op_signed, sa, sb;
  logic [DATA_W-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod, prod_fix;

  // Both units iterate on magnitudes; signs are reapplied when the result is written.
  assign op_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign sa        = op_signed & a_i[DATA_W-1];
  assign sb        = op_signed & b_i[DATA_W-1];
  assign a_mag     = sa ? -a_i : a_i;
  assign b_mag     = sb ? -b_i : b_i;

  assign mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opd_q} : '0);
  assign div_shift = {acc_q, wrk_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};

  // Divide-by-zero keeps the all-ones quotient unnegated; the remainder already equals the dividend.
  assign prod     = {acc_q, wrk_q};
  assign prod_fix = neg_x_q ? -prod : prod;
  assign quo_fix  = (neg_x_q & ~div0_q) ? -wrk_q : wrk_q;
  assign rem_fix  = neg_a_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    opd_d    = opd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_x_d  = neg_x_q;
    neg_a_d  = neg_a_q;
    div0_d   = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          state_d  = ST_BUSY;
          cnt_d    = '0;
          acc_d    = '0;
          wrk_d    = a_mag;
          opd_d    = b_mag;
          is_div_d = (op_i == MD_DIV) || (op_i == MD_DIVU);
          neg_x_d  = sa ^ sb;
          neg_a_d  = sa;
          div0_d   = (b_i == '0);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
          wrk_d = {wrk_q[DATA_W-2:0], ~div_diff[DATA_W]};
        end else begin
          acc_d = mul_sum[DATA_W:1];
          wrk_d = {mul_sum[0], wrk_q[DATA_W-1:1]};
        end
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      opd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_x_q  <= 1'b0;
      neg_a_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      opd_q    <= opd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_x_q  <= neg_x_d;
      neg_a_q  <= neg_a_d;
      div0_q   <= div0_d;
    end
  end

  assign state_o = state_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
endmodule
`endif

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding, ALU, EX/MEM register, optional mul/div unit (EX_MULDIV_EN).
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_stage_md_if.slave ex_if
);
  logic [DATA_W-1:0] fwd_a, fwd_b, op_a, op_b, alu_y, mf_val, result_d, result_q, store_q;
  logic              alu_zero, is_start, is_mf, stall_c, valid_d, valid_q, zero_q;
  logic [4:0]        rd_q;

  always_comb begin
    case (ex_if.forwardA)
      FWD_EXMEM: fwd_a = ex_if.ex_mem_result_in;
      FWD_MEMWB: fwd_a = ex_if.mem_wb_result_in;
      default:   fwd_a = ex_if.reg_data1_in;
    endcase
    case (ex_if.forwardB)
      FWD_EXMEM: fwd_b = ex_if.ex_mem_result_in;
      FWD_MEMWB: fwd_b = ex_if.mem_wb_result_in;
      default:   fwd_b = ex_if.reg_data2_in;
    endcase
  end

  assign op_a = ex_if.use_shamt_in ? DATA_W'(ex_if.shamt_in) : fwd_a;
  assign op_b = ex_if.alu_src_in ? ex_if.imm_in : fwd_b;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a_i    (op_a),
    .b_i    (op_b),
    .ctrl_i (ex_if.alu_control_in),
    .y_c    (alu_y),
    .zero_c (alu_zero)
  );

  assign is_start = md_is_start(ex_if.md_op_in);
  assign is_mf    = md_is_mf(ex_if.md_op_in);

`ifdef EX_MULDIV_EN
  md_state_e         md_state;
  logic [DATA_W-1:0] hi, lo;

  muldiv_iter #(.DATA_W(DATA_W)) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (ex_if.in_valid & is_start),
    .flush_i (ex_if.flush_in),
    .op_i    (ex_if.md_op_in),
    .a_i     (fwd_a),
    .b_i     (fwd_b),
    .state_o (md_state),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  // Start ops hold the front end until DONE; HI/LO reads wait for the unit to go idle.
  assign stall_c = ex_if.in_valid &
                   ((is_start & (md_state != ST_DONE)) | (is_mf & (md_state != ST_IDLE)));
  assign mf_val  = (ex_if.md_op_in == MD_MFHI) ? hi : lo;
`else
  assign stall_c = 1'b0;
  assign mf_val  = '0;
`endif

  assign valid_d  = ex_if.in_valid & ~ex_if.flush_in & ~stall_c;
  assign result_d = is_start ? '0 : (is_mf ? mf_val : alu_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      zero_q   <= 1'b0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= fwd_b;
      zero_q   <= alu_zero;
      rd_q     <= ex_if.rd_addr_in;
    end
  end

  assign ex_if.stall_out      = stall_c;
  assign ex_if.out_valid      = valid_q;
  assign ex_if.result_out     = result_q;
  assign ex_if.store_data_out = store_q;
  assign ex_if.zero_out       = zero_q;
  assign ex_if.rd_addr_out    = rd_q;
endmodule

// File: tb/tb_ex_stage_md.sv
// Randomized self-checking bench for ex_stage_md against a behavioural model (tracks EX_MULDIV_EN).
module tb_ex_stage_md;
  import ex_pkg::*;

  localparam int unsigned W = 32;
`ifdef EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, exm, mwb;
    logic [4:0]  shamt, rd;
    logic        src, ush;
    logic [3:0]  ctrl;
    logic [2:0]  md;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_md_if #(.DATA_W(W)) bus ();
  ex_stage_md #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .ex_if(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_sel(logic [1:0] sel, logic [31:0] rf, logic [31:0] exm,
                                          logic [31:0] mwb);
    if (sel == 2'b10) return exm;
    if (sel == 2'b01) return mwb;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = a % 32;
    case (c)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_ADD:  return a + b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return b << sh;
      ALU_SRL:  return b >> sh;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SRA:  return $signed(b) >>> sh;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_NOR:  return ~(a | b);
      default:  return 32'd0;
    endcase
  endfunction

  // Returns {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  function automatic stim_t mk(logic [2:0] md, logic [3:0] ctrl, logic [31:0] a, logic [31:0] b);
    stim_t s;
    s.fa = 2'b00; s.fb = 2'b00; s.rd1 = a; s.rd2 = b; s.imm = '0; s.exm = '0; s.mwb = '0;
    s.shamt = '0; s.rd = 5'd3; s.src = 1'b0; s.ush = 1'b0; s.ctrl = ctrl; s.md = md;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.forwardA = s.fa; bus.forwardB = s.fb;
    bus.reg_data1_in = s.rd1; bus.reg_data2_in = s.rd2; bus.imm_in = s.imm;
    bus.ex_mem_result_in = s.exm; bus.mem_wb_result_in = s.mwb;
    bus.shamt_in = s.shamt; bus.rd_addr_in = s.rd; bus.alu_src_in = s.src;
    bus.use_shamt_in = s.ush; bus.alu_control_in = s.ctrl; bus.md_op_in = s.md;
  endtask

  task automatic go_idle();
    bus.in_valid = 1'b0;
    bus.flush_in = 1'b0;
    bus.md_op_in = 3'd0;
  endtask

  // Presents one instruction, holds it through any stall, and checks the retired result.
  task automatic exec(input string tag, input stim_t s);
    logic [31:0] fa, fb, oa, ob, ar, er;
    logic [63:0] hl;
    bit          st, bub;
    int          stalls, exp_st;
    fa = fwd_sel(s.fa, s.rd1, s.exm, s.mwb);
    fb = fwd_sel(s.fb, s.rd2, s.exm, s.mwb);
    oa = s.ush ? {27'd0, s.shamt} : fa;
    ob = s.src ? s.imm : fb;
    ar = ref_alu(s.ctrl, oa, ob);
    st = s.md inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    exp_st = (MD_EN && st) ? int'(W) + 1 : 0;
    if (st) er = 32'd0;
    else if (s.md == MD_MFHI) er = m_hi;
    else if (s.md == MD_MFLO) er = m_lo;
    else er = ar;
    drive(s);
    bus.in_valid = 1'b1;
    bus.flush_in = 1'b0;
    #1;
    stalls = 0;
    bub = 1'b1;
    while (bus.stall_out && stalls < 200) begin
      stalls++;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) bub = 1'b0;
    end
    chk($sformatf("%s/stall_cycles", tag), 64'(stalls), 64'(exp_st));
    if (stalls > 0) chk($sformatf("%s/bubble", tag), 64'(bub), 64'd1);
    @(posedge clk); #1;
    go_idle();
    chk($sformatf("%s/valid", tag), 64'(bus.out_valid), 64'd1);
    chk($sformatf("%s/result", tag), 64'(bus.result_out), 64'(er));
    chk($sformatf("%s/store", tag), 64'(bus.store_data_out), 64'(fb));
    chk($sformatf("%s/zero", tag), 64'(bus.zero_out), 64'(ar == 32'd0));
    chk($sformatf("%s/rd", tag), 64'(bus.rd_addr_out), 64'(s.rd));
    if (MD_EN && st) begin
      hl = ref_md(s.md, fa, fb);
      m_hi = hl[63:32];
      m_lo = hl[31:0];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    drive(mk(MD_NONE, ALU_ADD, 32'd0, 32'd0));
    go_idle();
    #12;
    chk("reset/valid", 64'(bus.out_valid), 64'd0);
    chk("reset/result", 64'(bus.result_out), 64'd0);
    chk("reset/store", 64'(bus.store_data_out), 64'd0);
    chk("reset/zero", 64'(bus.zero_out), 64'd0);
    chk("reset/rd", 64'(bus.rd_addr_out), 64'd0);
    chk("reset/stall", 64'(bus.stall_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    s = mk(MD_NONE, ALU_ADD, 32'd100, 32'd7);
    s.fa = 2'b10; s.exm = 32'd5;
    exec("add_fwd", s);

    exec("multu", mk(MD_MULTU, ALU_ADD, 32'hFFFF_FFFF, 32'd2));
    exec("multu_mfhi", mk(MD_MFHI, ALU_ADD, 32'd0, 32'd0));
    exec("multu_mflo", mk(MD_MFLO, ALU_ADD, 32'd0, 32'd0));

    exec("div_neg", mk(MD_DIV, ALU_SUB, 32'hFFFF_FFF9, 32'd2));
    exec("div_neg_mflo", mk(MD_MFLO, ALU_ADD, 32'd0, 32'd0));
    exec("div_neg_mfhi", mk(MD_MFHI, ALU_ADD, 32'd0, 32'd0));
    exec("mult_m1", mk(MD_MULT, ALU_OR, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    exec("mult_m1_mfhi", mk(MD_MFHI, ALU_ADD, 32'd0, 32'd0));
    exec("mult_m1_mflo", mk(MD_MFLO, ALU_ADD, 32'd0, 32'd0));

    exec("divu_zero", mk(MD_DIVU, ALU_ADD, 32'd9, 32'd0));
    exec("divu_zero_mflo", mk(MD_MFLO, ALU_ADD, 32'd0, 32'd0));
    exec("divu_zero_mfhi", mk(MD_MFHI, ALU_ADD, 32'd0, 32'd0));
    exec("div_ovf", mk(MD_DIV, ALU_ADD, 32'h8000_0000, 32'hFFFF_FFFF));
    exec("div_ovf_mflo", mk(MD_MFLO, ALU_ADD, 32'd0, 32'd0));
    exec("div_ovf_mfhi", mk(MD_MFHI, ALU_ADD, 32'd0, 32'd0));

    for (int i = 0; i < 40; i++) begin
      s = mk(($urandom_range(0, 7) == 7) ? 3'd7 : 3'd0, 4'($urandom_range(0, 15)), pick(), pick());
      s.fa = 2'($urandom_range(0, 3)); s.fb = 2'($urandom_range(0, 3));
      s.exm = pick(); s.mwb = pick(); s.imm = pick();
      s.shamt = 5'($urandom_range(0, 31)); s.rd = 5'($urandom_range(0, 31));
      s.src = 1'($urandom_range(0, 1)); s.ush = 1'($urandom_range(0, 1));
      exec("rnd_alu", s);
    end

    for (int i = 0; i < 10; i++) begin
      s = mk(3'(1 + $urandom_range(0, 3)), 4'($urandom_range(0, 15)), pick(), pick());
      s.fa = 2'($urandom_range(0, 3)); s.fb = 2'($urandom_range(0, 3));
      s.exm = pick(); s.mwb = pick(); s.rd = 5'($urandom_range(0, 31));
      exec("rnd_md", s);
      exec("rnd_mfhi", mk(MD_MFHI, ALU_ADD, 32'd0, 32'd0));
      exec("rnd_mflo", mk(MD_MFLO, ALU_ADD, 32'd0, 32'd0));
    end

    // Make HI/LO nonzero so the flush and reset cases have something to preserve or clear.
    exec("pre_flush", mk(MD_MULTU, ALU_ADD, 32'h1234_5678, 32'h0000_0100));

    drive(mk(MD_NONE, ALU_ADD, 32'd1, 32'd2));
    bus.in_valid = 1'b1;
    bus.flush_in = 1'b1;
    @(posedge clk); #1;
    go_idle();
    chk("flush_idle/valid", 64'(bus.out_valid), 64'd0);

    drive(mk(MD_MULT, ALU_ADD, 32'd1234, 32'd99));
    bus.in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_in = 1'b1;
    @(posedge clk); #1;
    bus.flush_in = 1'b0;
    drive(mk(MD_MFHI, ALU_ADD, 32'd0, 32'd0));
    #1;
    chk("flush_busy/stall", 64'(bus.stall_out), 64'd0);
    chk("flush_busy/valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    go_idle();
    chk("flush_busy/mfhi_valid", 64'(bus.out_valid), 64'd1);
    chk("flush_busy/mfhi", 64'(bus.result_out), 64'(m_hi));
    exec("flush_busy_mflo", mk(MD_MFLO, ALU_ADD, 32'd0, 32'd0));

    s = mk(MD_MULTU, ALU_ADD, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    s.rd = 5'd17;
    drive(s);
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_busy/valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy/result", 64'(bus.result_out), 64'd0);
    chk("rst_busy/store", 64'(bus.store_data_out), 64'd0);
    chk("rst_busy/zero", 64'(bus.zero_out), 64'd0);
    chk("rst_busy/rd", 64'(bus.rd_addr_out), 64'd0);
    go_idle();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exec("rst_add", mk(MD_NONE, ALU_ADD, 32'd40, 32'd2));
    exec("rst_mfhi", mk(MD_MFHI, ALU_ADD, 32'd0, 32'd0));
    exec("rst_mflo", mk(MD_MFLO, ALU_ADD, 32'd0, 32'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
